spi_serdes: RTL and testbench

SPI slave serializer/deserializer for mode 0: SCLK idles low, MOSI is sampled on SCLK rising edge, and MISO changes on the falling edge. All SPI pins are oversampled and synchronized into the single system clock domain. Each completed PACKET_WIDTH-bit word is presented in parallel with a one-cycle strobe, and a parallel word is shifted out on MISO. The block sits between an external SPI master and the on-chip register/control logic.

---
 rtl/spi_serdes.sv | 91 +++++++++
 tb/tb_spi_serdes.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/spi_serdes.sv
// SPI mode-0 slave serializer/deserializer, oversampled into the clk domain.
// Optional macro SPI_MISO_TRISTATE_EN: release spi_MISO to high-Z when not selected.
module spi_serdes #(
  parameter int PACKET_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    spi_SCLK,
  input  logic                    spi_SSEL,
  input  logic                    spi_MOSI,
  output logic                    spi_MISO,
  input  logic [PACKET_WIDTH-1:0] txData,
  input  logic                    load,
  output logic [PACKET_WIDTH-1:0] rxShiftReg,
  output logic                    dataReady
);

  localparam int CW = (PACKET_WIDTH > 1) ? $clog2(PACKET_WIDTH) : 1;

  logic [2:0]              sclk_q, sclk_d;
  logic [2:0]              ssel_q, ssel_d;
  logic [1:0]              mosi_q, mosi_d;
  logic [PACKET_WIDTH-1:0] rx_q, rx_d;
  logic [PACKET_WIDTH-1:0] tx_q, tx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    rdy_q, rdy_d;

  logic sclk_rise, sclk_fall, ssel_active, last_bit;

  // Edges come from the two oldest SCLK stages; MOSI's second stage lines up
  // with the stage that reveals the rising edge.
  assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
  assign ssel_active = ~ssel_q[2];
  assign last_bit    = (cnt_q == CW'(PACKET_WIDTH - 1));

  always_comb begin
    sclk_d = {sclk_q[1:0], spi_SCLK};
    ssel_d = {ssel_q[1:0], spi_SSEL};
    mosi_d = {mosi_q[0], spi_MOSI};
    rx_d   = rx_q;
    tx_d   = tx_q;
    cnt_d  = cnt_q;
    rdy_d  = 1'b0;

    if (!ssel_active) begin
      cnt_d = '0;
    end else if (sclk_rise) begin
      rx_d  = {rx_q[PACKET_WIDTH-2:0], mosi_q[1]};
      cnt_d = last_bit ? '0 : cnt_q + 1'b1;
      rdy_d = last_bit;
    end

    // A parallel load wins over a coincident falling-edge shift.
    if (load) begin
      tx_d = txData;
    end else if (sclk_fall && ssel_active) begin
      tx_d = {tx_q[PACKET_WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q <= 3'b000;
      ssel_q <= 3'b111;
      mosi_q <= 2'b00;
      rx_q   <= '0;
      tx_q   <= '0;
      cnt_q  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      sclk_q <= sclk_d;
      ssel_q <= ssel_d;
      mosi_q <= mosi_d;
      rx_q   <= rx_d;
      tx_q   <= tx_d;
      cnt_q  <= cnt_d;
      rdy_q  <= rdy_d;
    end
  end

  assign rxShiftReg = rx_q;
  assign dataReady  = rdy_q;

`ifdef SPI_MISO_TRISTATE_EN
  assign spi_MISO = ssel_active ? tx_q[PACKET_WIDTH-1] : 1'bz;
`else
  assign spi_MISO = ssel_active ? tx_q[PACKET_WIDTH-1] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_serdes.sv
// Bench for spi_serdes: table-driven SPI words, reset corner cases and
// randomized words checked against a word-level model of the SPI link.
module tb_spi_serdes;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_SCLK, spi_SSEL, spi_MOSI;
  logic       spi_MISO;
  logic [7:0] txData;
  logic       load;
  logic [7:0] rxShiftReg;
  logic       dataReady;

  spi_serdes #(.PACKET_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .spi_SCLK   (spi_SCLK),
    .spi_SSEL   (spi_SSEL),
    .spi_MOSI   (spi_MOSI),
    .spi_MISO   (spi_MISO),
    .txData     (txData),
    .load       (load),
    .rxShiftReg (rxShiftReg),
    .dataReady  (dataReady)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse monitor: counts clk cycles with dataReady high and records context.
  int         total_pulses = 0;
  int         rise_cnt = 0;
  int         pulse_bit = 0;
  logic [7:0] pulse_rx = '0;

  always @(negedge clk) begin
    if (dataReady === 1'b1) begin
      total_pulses <= total_pulses + 1;
      pulse_bit    <= rise_cnt;
      pulse_rx     <= rxShiftReg;
    end
  end

`ifdef SPI_MISO_TRISTATE_EN
  localparam logic IDLE_MISO = 1'bz;
`else
  localparam logic IDLE_MISO = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic load_word(input logic [7:0] w);
    @(negedge clk);
    txData = w;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  // One SPI period is 10 clk; MISO is sampled just before each SCLK rise.
  task automatic spi_bits(input logic [7:0] w, input int n, output logic [7:0] miso_w);
    miso_w   = '0;
    rise_cnt = 0;
    for (int i = 0; i < n; i++) begin
      spi_MOSI = w[7-i];
      repeat (5) @(negedge clk);
      miso_w   = {miso_w[6:0], spi_MISO};
      spi_SCLK = 1'b1;
      rise_cnt = rise_cnt + 1;
      repeat (5) @(negedge clk);
      spi_SCLK = 1'b0;
    end
    repeat (6) @(negedge clk);
  endtask

  typedef struct {
    logic       do_load;
    logic [7:0] tx;
    logic [7:0] mosi;
    int         nbits;
    logic       ssel_high_after;
    int         exp_pulses;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [7:0] mw;
    int         base;

    vecs[0] = '{1'b1, 8'hC3, 8'hAB, 8, 1'b0, 1, 8'hAB, 8'hC3};
    vecs[1] = '{1'b0, 8'h00, 8'h15, 8, 1'b1, 1, 8'h15, 8'h00};
    vecs[2] = '{1'b0, 8'h00, 8'hFF, 4, 1'b1, 0, 8'h5F, 8'h00};
    vecs[3] = '{1'b1, 8'h96, 8'h5A, 8, 1'b1, 1, 8'h5A, 8'h96};

    reset = 1'b1; spi_SCLK = 1'b0; spi_SSEL = 1'b1; spi_MOSI = 1'b0;
    txData = '0; load = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'b0, dataReady}, 32'd0);
    check("reset_rx", {24'b0, rxShiftReg}, 32'h00);
    check("reset_miso", {31'b0, spi_MISO}, {31'b0, IDLE_MISO});
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_miso", {31'b0, spi_MISO}, {31'b0, IDLE_MISO});

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].do_load) load_word(vecs[v].tx);
      if (spi_SSEL) begin
        spi_SSEL = 1'b0;
        repeat (5) @(negedge clk);
      end
      base = total_pulses;
      spi_bits(vecs[v].mosi, vecs[v].nbits, mw);
      check($sformatf("vec%0d_pulses", v), total_pulses - base, vecs[v].exp_pulses);
      check($sformatf("vec%0d_rx", v), {24'b0, rxShiftReg}, {24'b0, vecs[v].exp_rx});
      check($sformatf("vec%0d_miso", v), {24'b0, mw}, {24'b0, vecs[v].exp_miso});
      if (vecs[v].exp_pulses == 1) begin
        check($sformatf("vec%0d_pulse_bit", v), pulse_bit, 8);
        check($sformatf("vec%0d_pulse_rx", v), {24'b0, pulse_rx}, {24'b0, vecs[v].exp_rx});
      end
      if (vecs[v].ssel_high_after) begin
        spi_SSEL = 1'b1;
        repeat (5) @(negedge clk);
      end
    end

    // Reset in the middle of a word, then a clean word.
    spi_SSEL = 1'b0;
    repeat (5) @(negedge clk);
    base = total_pulses;
    spi_bits(8'hE0, 3, mw);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_rx", {24'b0, rxShiftReg}, 32'h00);
    check("midreset_ready", {31'b0, dataReady}, 32'd0);
    check("midreset_miso", {31'b0, spi_MISO}, {31'b0, IDLE_MISO});
    reset = 1'b0;
    repeat (5) @(negedge clk);
    spi_bits(8'h81, 8, mw);
    check("postreset_pulses", total_pulses - base, 1);
    check("postreset_rx", {24'b0, rxShiftReg}, 32'h81);
    check("postreset_pulse_bit", pulse_bit, 8);
    check("postreset_miso", {24'b0, mw}, 32'h00);

    // Randomized words: the link should deliver each MOSI word intact and
    // return the loaded word on MISO (zeros once the shifter has drained).
    for (int k = 0; k < 20; k++) begin
      logic [7:0] tx_w, mosi_w, exp_miso;
      logic       do_load;
      tx_w    = 8'($urandom);
      mosi_w  = 8'($urandom);
      do_load = 1'($urandom_range(0, 1));
      exp_miso = do_load ? tx_w : 8'h00;
      if (do_load) load_word(tx_w);
      if (spi_SSEL) begin
        spi_SSEL = 1'b0;
        repeat (5) @(negedge clk);
      end
      base = total_pulses;
      spi_bits(mosi_w, 8, mw);
      check($sformatf("rand%0d_pulses", k), total_pulses - base, 1);
      check($sformatf("rand%0d_rx", k), {24'b0, rxShiftReg}, {24'b0, mosi_w});
      check($sformatf("rand%0d_miso", k), {24'b0, mw}, {24'b0, exp_miso});
      if ($urandom_range(0, 3) == 0) begin
        spi_SSEL = 1'b1;
        repeat (5) @(negedge clk);
      end
    end

    spi_SSEL = 1'b1;
    repeat (5) @(negedge clk);
    check("final_miso", {31'b0, spi_MISO}, {31'b0, IDLE_MISO});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
